alu_share_arb: RTL
==================

// Module: alu_share_arb
// PURPOSE
//  Shares one combinational ALU (4-bit op; ADD=0 SUB=1 AND=2 OR=3 XOR=4 SRA=5 SRL=6 SLL=7 SLT=8)
//  between two requesters: req0 is the core execute path and req1 is the address-gen/aux path.
//  A round-robin arbiter selects one request per cycle. The selected request goes through the ALU
//  into a single registered response stage with valid/ready backpressure. Throughput is 1 op/cycle.
// PARAMETERS
//  DATA_W  32  operand/result width; must be 32 to match the ALU
//  TAG_W   4   opaque requester tag, returned unchanged with the result
// PORTS
//  clk         in   1       system clock, rising edge
//  rst_n       in   1       asynchronous active-low reset
//  flush       in   1       synchronous drop of the pending response
//  req0_valid  in   1       requester 0 holds a request
//  req0_ready  out  1       requester 0 request accepted this cycle
//  req0_op     in   4       ALU op code
//  req0_a      in   DATA_W  operand a
//  req0_b      in   DATA_W  operand b (shift amount = b[4:0])
//  req0_tag    in   TAG_W   tag
//  req1_*      -    -       same set of ports as req0_*, for requester 1
//  rsp_valid   out  1       response register full
//  rsp_ready   in   1       consumer takes the response
//  rsp_id      out  1       requester index (0/1) that owns the response
//  rsp_tag     out  TAG_W   echoed tag
//  rsp_data    out  DATA_W  ALU result
//  rsp_err     out  1       op code was illegal (9..15)
// BEHAVIOUR
//  - Reset: rsp_valid=0, rsp_data=0, rsp_tag=0, rsp_id=0, rsp_err=0, rr_last=1, so req0 wins the first tie.
//  - accept = !rsp_valid | rsp_ready. This is a pipeline stage with no skid buffer.
//  - Grant, combinational:
//      - If only one requester is valid, that requester is granted.
//      - If both are valid, grant ~rr_last.
//      - reqN_ready = accept & grantN. It may depend combinationally on reqN_valid. At most one ready per cycle.
//  - Transfer happens when reqN_valid & reqN_ready. On the next edge:
//      - rsp_valid=1.
//      - rsp_data=ALU(op,a,b), rsp_tag=tag, rsp_id=N, rsp_err=(op>8).
//      - rr_last=N.
//  - Latency from accepted request to rsp_valid is 1 cycle.
//  - A new transfer in the same cycle as rsp_valid&rsp_ready replaces the response with no bubble.
//  - If the response is consumed and there is no new transfer, rsp_valid goes to 0.
//  - While rsp_valid & !rsp_ready: rsp_* hold stable and both readies are 0.
//  - rr_last updates only on a transfer. An idle cycle or a stall does not change priority.
//  - Illegal op: rsp_data=0, rsp_err=1. Handshake and arbitration behave as for a legal op.
//  - Arithmetic is modulo 2^32. SLT is signed and overflow-correct (33-bit compare), result in {31'b0,lt}.
//  - flush=1: rsp_valid<=0 and both readies are forced to 0 that cycle. rr_last is unchanged.
//  - flush has priority over rsp_ready and over any new transfer.
//  - rst_n low at any time, including mid-stall, clears everything to reset values immediately. The pending response is lost.
//  - A requester must hold valid/op/a/b/tag stable until ready. This is checked by assertion, not by the RTL.
//  - Two-state view: EMPTY (rsp_valid=0) / FULL (rsp_valid=1).
//      - EMPTY->FULL on a transfer.
//      - FULL->EMPTY on rsp_ready with no transfer, or on flush.
//      - FULL->FULL on a stall or on back-to-back transfers.
// STRUCTURE
//  - Shared package alu_pkg: ALU_OP_W=4 and the op localparams ADD..SLT.
//  - alu_pkg also holds ALU_OP_LAST=8, which is used for the rsp_err check.
//  - Instantiates the team's combinational alu once; its operands and op are muxed by the grant.
//  - One natural sub-module: rr_arb2, a two-way round-robin arbiter with valid inputs, an advance enable and a one-hot grant.
// TESTING
//  1. req0 only, ADD a=5 b=7 tag=3, rsp_ready=1 -> next cycle rsp_valid=1, data=12, id=0, tag=3, err=0.
//  2. Both valid every cycle from reset, rsp_ready=1 -> grants 0,1,0,1; zero bubbles; one response per cycle.
//  3. rsp_ready=0 for 3 cycles with both valid -> rsp_* stable, req0_ready=req1_ready=0, rr_last unchanged.
//  4. Ops through req1:
//      - SUB 3-5 -> 0xFFFFFFFE.
//      - SRA 0xF0000000 by 4 -> 0xFF000000.
//      - SRL 0xF0000000 by 4 -> 0x0F000000.
//      - SLL 1 by 31 -> 0x80000000.
//      - SLT 0x80000000 vs 1 -> 1.
//      - SLT 0x7FFFFFFF vs 0xFFFFFFFF -> 0.
//  5. op=4'hF a=1 b=1 -> rsp_err=1, data=0. The next legal op clears err.
//  6. Flush and reset:
//      - flush while FULL and stalled -> rsp_valid=0 next cycle, no ready that cycle.
//      - rst_n low mid-stall -> all outputs 0 asynchronously; first tie after reset goes to req0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: op codes, the last legal op, and the response-stage state type.
package alu_pkg;

    localparam int ALU_OP_W = 4;

    localparam logic [ALU_OP_W-1:0] ALU_ADD = 4'd0;
    localparam logic [ALU_OP_W-1:0] ALU_SUB = 4'd1;
    localparam logic [ALU_OP_W-1:0] ALU_AND = 4'd2;
    localparam logic [ALU_OP_W-1:0] ALU_OR  = 4'd3;
    localparam logic [ALU_OP_W-1:0] ALU_XOR = 4'd4;
    localparam logic [ALU_OP_W-1:0] ALU_SRA = 4'd5;
    localparam logic [ALU_OP_W-1:0] ALU_SRL = 4'd6;
    localparam logic [ALU_OP_W-1:0] ALU_SLL = 4'd7;
    localparam logic [ALU_OP_W-1:0] ALU_SLT = 4'd8;

    // Codes above this value are illegal and flagged on rsp_err.
    localparam logic [ALU_OP_W-1:0] ALU_OP_LAST = ALU_SLT;

    typedef enum logic {
        RSP_EMPTY = 1'b0,
        RSP_FULL  = 1'b1
    } rsp_state_e;

endpackage

// File: rtl/alu_share_arb_if.sv
// Bundle of the two request channels, the response channel, flush and debug visibility.
interface alu_share_arb_if #(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 4
);
    import alu_pkg::*;

    // Handshake: a beat moves on a rising edge where valid && ready. The producer keeps valid
    // and payload stable until it sees ready; ready may depend combinationally on valid.
    logic                flush;

    logic                req0_valid;
    logic                req0_ready;
    logic [ALU_OP_W-1:0] req0_op;
    logic [DATA_W-1:0]   req0_a;
    logic [DATA_W-1:0]   req0_b;
    logic [TAG_W-1:0]    req0_tag;

    logic                req1_valid;
    logic                req1_ready;
    logic [ALU_OP_W-1:0] req1_op;
    logic [DATA_W-1:0]   req1_a;
    logic [DATA_W-1:0]   req1_b;
    logic [TAG_W-1:0]    req1_tag;

    logic                rsp_valid;
    logic                rsp_ready;
    logic                rsp_id;
    logic [TAG_W-1:0]    rsp_tag;
    logic [DATA_W-1:0]   rsp_data;
    logic                rsp_err;

    rsp_state_e          dbg_state;
    logic                dbg_rr_last;

    modport master (
        output flush,
        output req0_valid, req0_op, req0_a, req0_b, req0_tag,
        input  req0_ready,
        output req1_valid, req1_op, req1_a, req1_b, req1_tag,
        input  req1_ready,
        input  rsp_valid, rsp_id, rsp_tag, rsp_data, rsp_err,
        output rsp_ready,
        input  dbg_state, dbg_rr_last
    );

    modport slave (
        input  flush,
        input  req0_valid, req0_op, req0_a, req0_b, req0_tag,
        output req0_ready,
        input  req1_valid, req1_op, req1_a, req1_b, req1_tag,
        output req1_ready,
        output rsp_valid, rsp_id, rsp_tag, rsp_data, rsp_err,
        input  rsp_ready,
        output dbg_state, dbg_rr_last
    );

endinterface

// File: rtl/alu.sv
// Combinational 32-bit ALU; illegal op codes produce zero.
module alu
    import alu_pkg::*;
(
    input  logic [ALU_OP_W-1:0] op,
    input  logic [31:0]         a,
    input  logic [31:0]         b,
    output logic [31:0]         y
);

    logic lt;

    // Sign-extending to 33 bits keeps the compare correct across overflow.
    assign lt = ($signed({a[31], a}) < $signed({b[31], b}));

    always_comb begin
        y = '0;
        case (op)
            ALU_ADD: y = a + b;
            ALU_SUB: y = a - b;
            ALU_AND: y = a & b;
            ALU_OR:  y = a | b;
            ALU_XOR: y = a ^ b;
            ALU_SRA: y = $signed(a) >>> b[4:0];
            ALU_SRL: y = a >> b[4:0];
            ALU_SLL: y = a << b[4:0];
            ALU_SLT: y = {31'b0, lt};
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; priority moves only when advance is high.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] valid,
    input  logic       advance,
    output logic [1:0] grant,
    output logic       rr_last
);

    always_comb begin
        grant = valid;
        if (valid == 2'b11) begin
            grant = rr_last ? 2'b01 : 2'b10;
        end
    end

    // Reset to 1 so requester 0 wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_last <= 1'b1;
        end else if (advance) begin
            rr_last <= grant[1];
        end
    end

endmodule

// File: rtl/alu_share_arb.sv
// One shared ALU behind a round-robin arbiter, feeding a single registered response stage.
module alu_share_arb
    import alu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    alu_share_arb_if.slave  bus
);

    logic [1:0]          grant;
    logic                rr_last;
    logic                accept;
    logic                xfer0;
    logic                xfer1;
    logic                xfer;
    logic [ALU_OP_W-1:0] sel_op;
    logic [DATA_W-1:0]   sel_a;
    logic [DATA_W-1:0]   sel_b;
    logic [TAG_W-1:0]    sel_tag;
    logic [DATA_W-1:0]   alu_y;
    rsp_state_e          state_q;
    rsp_state_e          state_d;

    logic                rsp_id_q;
    logic [TAG_W-1:0]    rsp_tag_q;
    logic [DATA_W-1:0]   rsp_data_q;
    logic                rsp_err_q;

    // No skid buffer: accept only when the stage is free or draining; flush and reset block it.
    assign accept = rst_n && !bus.flush && ((state_q == RSP_EMPTY) || bus.rsp_ready);

    rr_arb2 u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .valid   ({bus.req1_valid, bus.req0_valid}),
        .advance (xfer),
        .grant   (grant),
        .rr_last (rr_last)
    );

    assign bus.req0_ready = accept && grant[0];
    assign bus.req1_ready = accept && grant[1];
    assign xfer0          = bus.req0_valid && bus.req0_ready;
    assign xfer1          = bus.req1_valid && bus.req1_ready;
    assign xfer           = xfer0 || xfer1;

    assign sel_op  = grant[1] ? bus.req1_op  : bus.req0_op;
    assign sel_a   = grant[1] ? bus.req1_a   : bus.req0_a;
    assign sel_b   = grant[1] ? bus.req1_b   : bus.req0_b;
    assign sel_tag = grant[1] ? bus.req1_tag : bus.req0_tag;

    alu u_alu (
        .op (sel_op),
        .a  (sel_a),
        .b  (sel_b),
        .y  (alu_y)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RSP_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RSP_EMPTY: if (xfer) state_d = RSP_FULL;
            RSP_FULL: begin
                if (bus.flush)          state_d = RSP_EMPTY;
                else if (xfer)          state_d = RSP_FULL;
                else if (bus.rsp_ready) state_d = RSP_EMPTY;
            end
            default: state_d = RSP_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_id_q   <= 1'b0;
            rsp_tag_q  <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else if (xfer) begin
            rsp_id_q   <= grant[1];
            rsp_tag_q  <= sel_tag;
            rsp_data_q <= alu_y;
            rsp_err_q  <= (sel_op > ALU_OP_LAST);
        end
    end

    assign bus.rsp_valid   = (state_q == RSP_FULL);
    assign bus.rsp_id      = rsp_id_q;
    assign bus.rsp_tag     = rsp_tag_q;
    assign bus.rsp_data    = rsp_data_q;
    assign bus.rsp_err     = rsp_err_q;
    assign bus.dbg_state   = state_q;
    assign bus.dbg_rr_last = rr_last;

    // Requesters must not withdraw or alter a request before it is accepted.
    req0_hold: assert property (@(posedge clk) disable iff (!rst_n)
        (bus.req0_valid && !bus.req0_ready) |=>
        (bus.req0_valid && $stable({bus.req0_op, bus.req0_a, bus.req0_b, bus.req0_tag})));

    req1_hold: assert property (@(posedge clk) disable iff (!rst_n)
        (bus.req1_valid && !bus.req1_ready) |=>
        (bus.req1_valid && $stable({bus.req1_op, bus.req1_a, bus.req1_b, bus.req1_tag})));

endmodule
